ram_burst_reader: RTL and testbench

- Burst read sequencer for the ram_dp read port: takes a (start address, word count) command, issues read_en/read_addr to the RAM, and emits the words as a valid/ready stream with a last flag.
- Absorbs the RAM's 1-cycle registered read latency and downstream backpressure using a 2-entry output buffer with credit-based issue.
- Sustains 1 word/cycle when out_ready is held high.
- Sits in the RAM's read clock domain.

---
 rtl/ram_burst_reader.sv | 201 ++++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst read sequencer for the ram_dp read port: turns (address, count) commands into
// a valid/ready word stream, hiding the RAM's one-cycle read latency behind a 2-entry buffer.
module ram_burst_reader_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] occ,
  input logic       data_valid,
  input logic       pop
);

  // A word arriving from the RAM must always find room in the buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(occ == 2'd2 && data_valid && !pop))
    else $error("ram_burst_reader: output buffer overflow");

  // Occupancy never leaves its legal range.
  assert property (@(posedge clk) disable iff (!rst_n) occ != 2'd3)
    else $error("ram_burst_reader: illegal buffer occupancy");

endmodule

module ram_burst_reader #(
  parameter int DataWidth  = 8,
  parameter int AddrWidth  = 10,
  parameter int CountWidth = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AddrWidth-1:0]  start_addr,
  input  logic [CountWidth-1:0] start_count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_en,
  output logic [AddrWidth-1:0]  ram_read_addr,
  input  logic [DataWidth-1:0]  ram_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DataWidth-1:0]  out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [AddrWidth-1:0]  addr_r;
  logic [CountWidth-1:0] count_r;
  logic [CountWidth-1:0] issued_r;
  logic [CountWidth-1:0] delivered_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  rd_en_r;
  logic [AddrWidth-1:0]  rd_addr_r;
  logic                  dv_r;
  logic [1:0]            occ_r;
  logic [DataWidth-1:0]  buf0_r;
  logic [DataWidth-1:0]  buf1_r;

  logic                  out_valid_s;
  logic [DataWidth-1:0]  head_s;
  logic                  pop_s;
  logic                  last_s;
  logic [2:0]            held_s;
  logic                  issue_s;

  // Stream head, handshake and read-issue credit decision.
  always_comb begin
    out_valid_s = 1'b0;
    head_s      = {DataWidth{1'b0}};
    // An empty buffer forwards the word currently on the RAM bus so no cycle is lost.
    if (occ_r != 2'd0) begin
      out_valid_s = 1'b1;
      head_s      = buf0_r;
    end else if (dv_r) begin
      out_valid_s = 1'b1;
      head_s      = ram_read_data;
    end else begin
      out_valid_s = 1'b0;
      head_s      = {DataWidth{1'b0}};
    end
    pop_s  = out_valid_s && out_ready;
    last_s = out_valid_s && (delivered_r == count_r - CountWidth'(1));
    // Words held or owed to the buffer: buffered, on the RAM bus, and being read now.
    held_s = {1'b0, occ_r} + {2'b00, dv_r} + {2'b00, rd_en_r} - {2'b00, pop_s};
    if (state_r == RUN && issued_r < count_r && held_s < 3'd2) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Control FSM, RAM read issue, output buffer and burst counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {AddrWidth{1'b0}};
      count_r     <= {CountWidth{1'b0}};
      issued_r    <= {CountWidth{1'b0}};
      delivered_r <= {CountWidth{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {AddrWidth{1'b0}};
      dv_r        <= 1'b0;
      occ_r       <= 2'd0;
      buf0_r      <= {DataWidth{1'b0}};
      buf1_r      <= {DataWidth{1'b0}};
    end else begin
      done_r  <= 1'b0;
      dv_r    <= rd_en_r;
      rd_en_r <= issue_s;
      if (issue_s) begin
        rd_addr_r <= addr_r;
        addr_r    <= addr_r + AddrWidth'(1);
        issued_r  <= issued_r + CountWidth'(1);
      end

      case (occ_r)
        2'd0: begin
          if (dv_r && !pop_s) begin
            buf0_r <= ram_read_data;
            occ_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop_s && dv_r) begin
            buf0_r <= ram_read_data;
          end else if (pop_s) begin
            occ_r <= 2'd0;
          end else if (dv_r) begin
            buf1_r <= ram_read_data;
            occ_r  <= 2'd2;
          end
        end
        2'd2: begin
          if (pop_s) begin
            buf0_r <= buf1_r;
            if (dv_r) begin
              buf1_r <= ram_read_data;
            end else begin
              occ_r <= 2'd1;
            end
          end
        end
        default: occ_r <= 2'd0;
      endcase

      if (pop_s) begin
        delivered_r <= delivered_r + CountWidth'(1);
      end
      if (pop_s && last_s) begin
        busy_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start && !busy_r) begin
            if (start_count == {CountWidth{1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              state_r     <= RUN;
              busy_r      <= 1'b1;
              addr_r      <= start_addr;
              count_r     <= start_count;
              issued_r    <= {CountWidth{1'b0}};
              delivered_r <= {CountWidth{1'b0}};
            end
          end
        end
        RUN: begin
          if (delivered_r == count_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign ram_read_en   = rd_en_r;
  assign ram_read_addr = rd_addr_r;
  assign out_valid     = out_valid_s;
  assign out_data      = head_s;
  assign out_last      = last_s;

  ram_burst_reader_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .occ        (occ_r),
    .data_valid (dv_r),
    .pop        (pop_s)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a RAM model with mem[i]=i, expected reads and
// words queued at command time, and a negedge monitor that checks the stream and read port.
module tb_ram_burst_reader;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, ram_read_en, out_valid, out_ready, out_last;
  logic [AW-1:0] start_addr, ram_read_addr;
  logic [CW-1:0] start_count;
  logic [DW-1:0] ram_read_data = 8'h00;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_fail = 0;
  int issued_m = 0;
  int popped_m = 0;
  int pop_total = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = 8'h00;
  logic          bp_on = 1'b0;
  logic [31:0]   bp_pat = 32'b11111111111111_100100000110011001;

  ram_burst_reader #(.DataWidth(DW), .AddrWidth(AW), .CountWidth(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .start_count(start_count), .busy(busy), .done(done), .ram_read_en(ram_read_en),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // RAM with a registered read port, contents mem[i] = low byte of i.
  always @(posedge clk) begin
    if (ram_read_en) ram_read_data <= ram_read_addr[DW-1:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Consumer ready: high, or a fixed stall pattern during the backpressure burst.
  initial begin
    int idx;
    idx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_on) begin
        out_ready = bp_pat[idx];
        if (idx < 31) idx++;
      end else begin
        out_ready = 1'b1;
        idx = 0;
      end
    end
  end

  // Monitor: read addresses, outstanding reads, stall stability and stream words.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_read_en) begin
        issued_m++;
        n_checks++;
        if (issued_m - popped_m > 2) begin
          n_fail++;
          $display("FAIL outstanding: got %0d, expected at most 2", issued_m - popped_m);
        end
        if (addr_q.size() == 0) fail_now("unexpected read");
        else check("read addr", 32'(ram_read_addr), 32'(addr_q.pop_front()));
      end
      if (prev_stall) check("stall hold", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        popped_m++;
        pop_total++;
        if (exp_q.size() == 0) fail_now("unexpected word");
        else check("word {last,data}", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [CW-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] ad;
      ad = a + AW'(i);
      addr_q.push_back(ad);
      exp_q.push_back({(i == int'(n) - 1), ad[DW-1:0]});
    end
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    start_count = n;
    push_exp(a, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follows a burst cycle by cycle (c=0 is the cycle after the accepting edge) until done.
  task automatic wait_done(input int inj, output int busy_cnt, output int first_valid,
                           output int done_at, output int en_cnt, output int first_en);
    busy_cnt = 0; first_valid = -1; done_at = -1; en_cnt = 0; first_en = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == inj) begin
        start = 1'b1;
        start_addr = 10'h100;
        start_count = 11'd3;
      end else if (c == inj + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (ram_read_en) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_at = c;
        break;
      end
    end
    if (done_at < 0) fail_now("done timeout");
  endtask

  initial begin
    int b, fv, d, e, fe, base, cyc, dn;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 10'h000;
    start_count = 11'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'({busy, done, ram_read_en, out_valid, out_last, ram_read_addr, out_data}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    start_burst(10'h010, 11'd4);
    wait_done(-1, b, fv, d, e, fe);
    check("basic busy cycles", b, 6);
    check("basic first valid", fv, 2);
    check("basic done cycle", d, 7);
    check("basic read count", e, 4);
    check("basic first read", fe, 1);
    @(negedge clk);
    check("basic done width", 32'(done), 32'd0);
    check("basic drained", exp_q.size() + addr_q.size(), 0);

    start_burst(10'h3FE, 11'd4);
    wait_done(-1, b, fv, d, e, fe);
    check("wrap drained", exp_q.size() + addr_q.size(), 0);

    bp_on = 1'b1;
    start_burst(10'h080, 11'd8);
    wait_done(-1, b, fv, d, e, fe);
    bp_on = 1'b0;
    check("backpressure drained", exp_q.size() + addr_q.size(), 0);

    start_burst(10'h055, 11'd0);
    wait_done(-1, b, fv, d, e, fe);
    check("zero done cycle", d, 0);
    check("zero busy cycles", b, 0);
    check("zero reads", e, 0);
    check("zero first valid", fv, -1);

    start_burst(10'h040, 11'd5);
    wait_done(3, b, fv, d, e, fe);
    check("busy start drained", exp_q.size() + addr_q.size(), 0);
    start = 1'b1;
    start_addr = 10'h100;
    start_count = 11'd3;
    push_exp(10'h100, 11'd3);
    @(negedge clk);
    check("start in DONE ignored", 32'(busy), 32'd0);
    @(negedge clk);
    check("start in IDLE accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(-1, b, fv, d, e, fe);
    check("after-done burst drained", exp_q.size() + addr_q.size(), 0);

    start_burst(10'h030, 11'd6);
    base = pop_total;
    cyc = 0;
    while (pop_total < base + 2 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) fail_now("reset burst timeout");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    issued_m = 0;
    popped_m = 0;
    @(negedge clk);
    check("abort outputs", 32'({busy, done, ram_read_en, out_valid, out_last, ram_read_addr, out_data}), 32'd0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no done after abort", dn, 0);
    start_burst(10'h020, 11'd2);
    wait_done(-1, b, fv, d, e, fe);
    check("post-reset drained", exp_q.size() + addr_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
